serial_chunk_adder: RTL



---
 rtl/serial_chunk_adder_pkg.sv | 14 +
 rtl/chunk_ripple_adder.sv | 25 ++
 rtl/serial_chunk_adder.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and configuration check for serial_chunk_adder.
package serial_chunk_adder_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // A legal configuration splits WIDTH into whole chunks of at least one bit.
  function automatic bit cfg_legal(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple-carry adder slice used by serial_chunk_adder.
module chunk_ripple_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  always_comb begin : ripple
    logic c;
    // NOTE: every output of a combinational block gets a value before any
    // conditional or loop logic, so no path can leave it unassigned (latch).
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: CHUNK bits per clock, LS chunk first, start/busy/done handshake.
// Optional macro SERIAL_CHUNK_ADDER_SUB_EN adds a 'sub' input selecting a - b.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if (!cfg_legal(WIDTH, CHUNK)) begin : g_cfg_check
    $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK with 1 <= CHUNK <= WIDTH");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_next;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;

  // Subtraction is folded in at acceptance: a - b == a + ~b + 1.
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .x  (op_a[cnt*CHUNK +: CHUNK]),
    .y  (op_b[cnt*CHUNK +: CHUNK]),
    .ci (c_reg),
    .s  (chunk_s),
    .co (chunk_co)
  );

  always_comb begin
    part_next = part;
    part_next[cnt*CHUNK +: CHUNK] = chunk_s;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      part  <= '0;
      c_reg <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          op_a  <= a;
          op_b  <= b_eff;
          c_reg <= cin_eff;
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        part  <= part_next;
        c_reg <= chunk_co;
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) begin
          sum   <= part_next;
          carry <= chunk_co;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

endmodule
